debounce_sync: RTL and testbench

- Input-conditioning stage that sits directly upstream of the team's d_ff register bank.
- Takes a raw asynchronous level, such as a push-button or an external strobe, and synchronises it into the clk domain.
- Filters out glitches and bounce shorter than a programmable window.
- Outputs a clean registered level for the downstream flop's d, plus single-cycle rise and fall pulses.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_sync_chain.sv | 21 ++
 rtl/debounce_sync.sv | 73 +++++++
 tb/tb_debounce_sync.sv | 121 ++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: state encoding and default parameters shared by the debounce_sync slice
package debounce_pkg;
    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b11,
        WAIT_LO = 2'b10
    } state_t;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 50000;
    localparam int DEF_CNT_W         = 16;
endpackage

// File: rtl/debounce_sync_chain.sv
// sync_chain: plain flop chain bringing an asynchronous level into the clk domain
module sync_chain
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] r;
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("sync_chain: SYNC_STAGES must be 2..4");
    end
    always_ff @(posedge clk) begin
        if (rst) r <= '0;
        else     r <= {r[SYNC_STAGES-2:0], d};
    end
    assign q = r[SYNC_STAGES-1];
endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronise, debounce and edge-detect a raw level; DEBOUNCE_BUSY_EN adds a busy output
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din_async,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse
`ifdef DEBOUNCE_BUSY_EN
    ,
    output logic busy
`endif
);
    if (STABLE_CYCLES < 2 || 2 ** CNT_W <= STABLE_CYCLES) begin : g_bad_cfg
        $error("debounce_sync: need STABLE_CYCLES >= 2 and 2**CNT_W > STABLE_CYCLES");
    end
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             s, rise_n, fall_n, idle, cur;
    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din_async),
        .q  (s)
    );
    // the encoding puts the debounced level in bit 1 and "waiting" in bit1^bit0
    assign cur  = state[1];
    assign idle = ~(state[1] ^ state[0]);
    assign dout = cur;
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        if (idle) begin
            state_n = (s != cur) ? (cur ? WAIT_LO : WAIT_HI) : state;
            cnt_n   = (s != cur) ? CNT_W'(1) : '0;
        end else if (s == cur) begin
            state_n = cur ? IDLE_HI : IDLE_LO;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            state_n = cur ? IDLE_LO : IDLE_HI;
            rise_n  = ~cur;
            fall_n  = cur;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE_LO;
            cnt        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rise_pulse <= rise_n;
            fall_pulse <= fall_n;
        end
    end
`ifdef DEBOUNCE_BUSY_EN
    always_ff @(posedge clk) begin
        if (rst) busy <= 1'b0;
        else     busy <= state_n[1] ^ state_n[0];
    end
`endif
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: random and directed stimulus checked against a run-length reference model via a scoreboard
module tb_debounce_sync;
    localparam int SS = 2;
    localparam int N  = 4;
    typedef struct packed {
        logic d;
        logic r;
        logic f;
        logic b;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_async = 1'b1;
    logic dout, rise_pulse, fall_pulse, busy;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   sh[SS];
    bit   m_dout = 1'b0;
    int   run = 0;
    always #5 clk = ~clk;
    debounce_sync #(.SYNC_STAGES(SS), .STABLE_CYCLES(N), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_async (din_async),
        .dout      (dout),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`ifdef DEBOUNCE_BUSY_EN
        ,
        .busy      (busy)
`endif
    );
`ifndef DEBOUNCE_BUSY_EN
    assign busy = 1'b0;
`endif
    task automatic chk(input string name, input logic got, input bit want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
        end
    endtask
    // model: dout flips once the synchronised input has disagreed with it for N consecutive cycles
    task automatic cyc(input bit r, input bit d);
        exp_t e;
        bit   s_old;
        rst       = r;
        din_async = d;
        @(posedge clk);
        e = '0;
        if (r) begin
            foreach (sh[i]) sh[i] = 1'b0;
            m_dout = 1'b0;
            run    = 0;
        end else begin
            s_old = sh[SS-1];
            for (int i = SS - 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = d;
            run = (s_old != m_dout) ? run + 1 : 0;
            if (run == N) begin
                e.r    = ~m_dout;
                e.f    = m_dout;
                m_dout = ~m_dout;
                run    = 0;
            end
        end
        e.d = m_dout;
        e.b = (run != 0);
        sb.push_back(e);
        #1;
    endtask
    task automatic hold(input bit d, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, d);
    endtask
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("dout", dout, e.d);
            chk("rise_pulse", rise_pulse, e.r);
            chk("fall_pulse", fall_pulse, e.f);
`ifdef DEBOUNCE_BUSY_EN
            chk("busy", busy, e.b);
`endif
        end
    end
    initial begin
        bit d;
        int len;
        repeat (3) cyc(1'b1, 1'b1);
        hold(1'b1, 8);
        hold(1'b0, 8);
        hold(1'b1, 3);
        hold(1'b0, 1);
        hold(1'b1, 10);
        hold(1'b0, 8);
        hold(1'b1, 1);
        hold(1'b0, 8);
        hold(1'b1, 3);
        cyc(1'b1, 1'b1);
        hold(1'b1, 8);
        hold(1'b0, 8);
        d = 1'b0;
        for (int k = 0; k < 150; k++) begin
            d   = ~d;
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 19) == 0) cyc(1'b1, d);
            hold(d, len);
        end
        hold(d, 8);
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
